// File: rtl/idct_pkg.sv
// Shared IDCT definitions: pass state encodings, the 8x8 cosine matrix C
// (Q-scaled integers) used by both the T and S passes, and default widths.
package idct_pkg;

    localparam int IDCT_DATA_W = 16;
    localparam int IDCT_ACC_W  = 32;
    localparam int IDCT_COEF_W = 13;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_FETCH,
        CS_DRAIN,
        CS_COMPUTE,
        CS_DONE
    } computeS_state_type;

    typedef enum logic [2:0] {
        CT_IDLE,
        CT_FETCH,
        CT_DRAIN,
        CT_COMPUTE,
        CT_DONE
    } computeT_state_type;

    // IDCT_C[k][j]: row k is the basis function index, column j the sample index.
    localparam logic signed [IDCT_COEF_W-1:0] IDCT_C [8][8] = '{
        '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
        '{ 13'sd2008,  13'sd1702,  13'sd1137,  13'sd399,  -13'sd399,  -13'sd1137, -13'sd1702, -13'sd2008},
        '{ 13'sd1892,  13'sd783,  -13'sd783,  -13'sd1892, -13'sd1892, -13'sd783,   13'sd783,   13'sd1892},
        '{ 13'sd1702, -13'sd399,  -13'sd2008, -13'sd1137,  13'sd1137,  13'sd2008,  13'sd399,  -13'sd1702},
        '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
        '{ 13'sd1137, -13'sd2008,  13'sd399,   13'sd1702, -13'sd1702, -13'sd399,   13'sd2008, -13'sd1137},
        '{ 13'sd783,  -13'sd1892,  13'sd1892, -13'sd783,  -13'sd783,   13'sd1892, -13'sd1892,  13'sd783},
        '{ 13'sd399,  -13'sd1137,  13'sd1702, -13'sd2008,  13'sd2008, -13'sd1702,  13'sd1137, -13'sd399}
    };

endpackage

// File: rtl/idct_dot8.sv
// Combinational 8-term signed dot product of a buffered S' row against
// column col_i of the shared C matrix.
module idct_dot8
    import idct_pkg::*;
#(
    parameter int DATA_W = IDCT_DATA_W,
    parameter int ACC_W  = IDCT_ACC_W
) (
    input  logic signed [DATA_W-1:0] row_i [8],
    input  logic        [2:0]        col_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    localparam int PROD_W = DATA_W + IDCT_COEF_W;

    logic signed [PROD_W-1:0] prod [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_prod
        assign prod[gi] = $signed(PROD_W'(row_i[gi])) * $signed(PROD_W'(IDCT_C[gi][col_i]));
    end

    // Products are sign-extended before summing; the 8-term sum of 29-bit
    // products cannot exceed the accumulator range.
    always_comb begin
        acc_o = '0;
        for (int i = 0; i < 8; i++) begin
            acc_o = acc_o + ACC_W'(prod[i]);
        end
    end

endmodule

// File: rtl/compute_t.sv
// Row pass of the 8x8 IDCT: fetches one S' row at a time, then writes
// T[row][j] = (S'row . C[:,j]) >>> SHIFT for j = 0..7.
module compute_t
    import idct_pkg::*;
#(
    parameter int DATA_W = IDCT_DATA_W,
    parameter int ACC_W  = IDCT_ACC_W,
    parameter int SHIFT  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     compute_t_start,
    output logic        [5:0]        sp_address,
    input  logic signed [DATA_W-1:0] sp_read_data,
    output logic        [5:0]        t_address,
    output logic signed [ACC_W-1:0]  t_write_data,
    output logic                     t_write_enable,
    output logic                     compute_t_finish
);

    computeT_state_type state_q, state_d;
    logic        [2:0]        row_q, row_d;
    logic        [2:0]        col_q, col_d;
    logic        [2:0]        k_q, k_d;
    logic signed [DATA_W-1:0] rowbuf_q [8];
    logic signed [DATA_W-1:0] rowbuf_d [8];
    logic        [5:0]        sp_address_q, sp_address_d;
    logic        [5:0]        t_address_q, t_address_d;
    logic signed [ACC_W-1:0]  t_write_data_q, t_write_data_d;
    logic                     t_write_enable_q, t_write_enable_d;
    logic                     finish_q, finish_d;

    logic        [2:0]        row_inc;
    logic        [2:0]        k_inc;
    logic signed [ACC_W-1:0]  acc;

    assign row_inc = row_q + 3'd1;
    assign k_inc   = k_q + 3'd1;

    idct_dot8 #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_dot8 (
        .row_i  (rowbuf_q),
        .col_i  (col_q),
        .acc_o  (acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= CT_IDLE;
            row_q            <= '0;
            col_q            <= '0;
            k_q              <= '0;
            sp_address_q     <= '0;
            t_address_q      <= '0;
            t_write_data_q   <= '0;
            t_write_enable_q <= 1'b0;
            finish_q         <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rowbuf_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            row_q            <= row_d;
            col_q            <= col_d;
            k_q              <= k_d;
            sp_address_q     <= sp_address_d;
            t_address_q      <= t_address_d;
            t_write_data_q   <= t_write_data_d;
            t_write_enable_q <= t_write_enable_d;
            finish_q         <= finish_d;
            rowbuf_q         <= rowbuf_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        k_d              = k_q;
        rowbuf_d         = rowbuf_q;
        sp_address_d     = sp_address_q;
        t_address_d      = t_address_q;
        t_write_data_d   = t_write_data_q;
        t_write_enable_d = 1'b0;
        finish_d         = 1'b0;

        unique case (state_q)
            CT_IDLE: begin
                if (compute_t_start) begin
                    row_d        = '0;
                    k_d          = '0;
                    sp_address_d = '0;
                    state_d      = CT_FETCH;
                end
            end
            CT_FETCH: begin
                // RAM data trails the address by one cycle, so word k-1 lands now.
                if (k_q != 3'd0) begin
                    rowbuf_d[k_q - 3'd1] = sp_read_data;
                end
                if (k_q == 3'd7) begin
                    k_d     = '0;
                    state_d = CT_DRAIN;
                end else begin
                    k_d          = k_inc;
                    sp_address_d = {row_q, k_inc};
                end
            end
            CT_DRAIN: begin
                rowbuf_d[7] = sp_read_data;
                col_d       = '0;
                state_d     = CT_COMPUTE;
            end
            CT_COMPUTE: begin
                t_address_d      = {row_q, col_q};
                t_write_data_d   = acc >>> SHIFT;
                t_write_enable_d = 1'b1;
                if (col_q == 3'd7) begin
                    col_d = '0;
                    if (row_q == 3'd7) begin
                        finish_d = 1'b1;
                        state_d  = CT_DONE;
                    end else begin
                        row_d        = row_inc;
                        k_d          = '0;
                        sp_address_d = {row_inc, 3'd0};
                        state_d      = CT_FETCH;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            CT_DONE: begin
                state_d = CT_IDLE;
            end
            default: begin
                state_d = CT_IDLE;
            end
        endcase
    end

    assign sp_address       = sp_address_q;
    assign t_address        = t_address_q;
    assign t_write_data     = t_write_data_q;
    assign t_write_enable   = t_write_enable_q;
    assign compute_t_finish = finish_q;

endmodule

// File: tb/tb_compute_t.sv
// Randomized bench for compute_t: an S' RAM model feeds the DUT and every
// T word is compared with a floor((S' x C) / 256) reference.
module tb_compute_t;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     compute_t_start;
    logic        [5:0]        sp_address;
    logic signed [DATA_W-1:0] sp_read_data;
    logic        [5:0]        t_address;
    logic signed [ACC_W-1:0]  t_write_data;
    logic                     t_write_enable;
    logic                     compute_t_finish;

    logic signed [15:0] sp_mem [64];
    longint             last_t [64];
    int                 n_checks = 0;
    int                 n_fails  = 0;

    int C_TB [8][8] = '{
        '{1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
        '{2008,  1702,  1137,   399,  -399, -1137, -1702, -2008},
        '{1892,   783,  -783, -1892, -1892,  -783,   783,  1892},
        '{1702,  -399, -2008, -1137,  1137,  2008,   399, -1702},
        '{1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
        '{1137, -2008,   399,  1702, -1702,  -399,  2008, -1137},
        '{ 783, -1892,  1892,  -783,  -783,  1892, -1892,   783},
        '{ 399, -1137,  1702, -2008,  2008, -1702,  1137,  -399}
    };

    always #5 clock = ~clock;

    always @(posedge clock) sp_read_data <= sp_mem[sp_address];

    compute_t dut (
        .clock            (clock),
        .reset            (reset),
        .compute_t_start  (compute_t_start),
        .sp_address       (sp_address),
        .sp_read_data     (sp_read_data),
        .t_address        (t_address),
        .t_write_data     (t_write_data),
        .t_write_enable   (t_write_enable),
        .compute_t_finish (compute_t_finish)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Dot product with true floor division by 256.
    function automatic longint model_t(input int idx);
        longint s = 0;
        longint q;
        for (int k = 0; k < 8; k++) begin
            s += longint'(sp_mem[(idx / 8) * 8 + k]) * longint'(C_TB[k][idx % 8]);
        end
        q = s / 256;
        if (s < 0 && (s % 256) != 0) q -= 1;
        return q;
    endfunction

    task automatic fill(input int mode);
        for (int i = 0; i < 64; i++) begin
            sp_mem[i] = (mode == 0) ? 16'sd0 : 16'($urandom);
        end
    endtask

    // Pulse start, watch up to 160 cycles (cycle 1 follows the sampling edge).
    // restart_at: extra start pulse cycle; abort_at: reset cycle;
    // tail: 0 = return on finish, 1 = check idle next cycle, 2 = start during DONE.
    task automatic run_block(input string tag, input int restart_at, input int abort_at, input int tail);
        int wr_count = 0;
        int fin_cyc  = -1;
        int fin_cnt  = 0;
        int stray_we = 0;
        @(negedge clock);
        compute_t_start = 1'b1;
        for (int cyc = 1; cyc <= 160; cyc++) begin
            @(negedge clock);
            compute_t_start = (cyc == restart_at);
            if (t_write_enable) begin
                if (wr_count == 0) check({tag, " first_wr_cycle"}, cyc, 11);
                check({tag, " wr_addr"}, t_address, wr_count);
                if (wr_count < 64) last_t[wr_count] = t_write_data;
                wr_count++;
            end
            if (compute_t_finish) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = cyc;
            end
            if (cyc == abort_at) begin
                reset = 1'b1;
                @(negedge clock);
                check({tag, " abort_we"}, t_write_enable, 0);
                check({tag, " abort_finish"}, compute_t_finish, 0);
                @(negedge clock);
                reset = 1'b0;
                repeat (20) begin
                    @(negedge clock);
                    if (t_write_enable || compute_t_finish) stray_we++;
                end
                check({tag, " abort_quiet"}, stray_we, 0);
                return;
            end
            if (fin_cnt > 0) break;
        end
        check({tag, " finish_cycle"}, fin_cyc, 137);
        check({tag, " write_count"}, wr_count, 64);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("%s T[%0d]", tag, i), last_t[i], model_t(i));
        end
        if (tail == 2) compute_t_start = 1'b1;
        if (tail >= 1) begin
            @(negedge clock);
            compute_t_start = 1'b0;
            check({tag, " finish_one_cycle"}, compute_t_finish, 0);
            check({tag, " idle_we"}, t_write_enable, 0);
        end
        if (tail == 2) begin
            repeat (30) begin
                @(negedge clock);
                if (t_write_enable || compute_t_finish) stray_we++;
            end
            check({tag, " start_in_done_ignored"}, stray_we, 0);
        end
    endtask

    initial begin
        reset           = 1'b1;
        compute_t_start = 1'b0;
        fill(0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset sp_address", sp_address, 0);
        check("reset t_address", t_address, 0);
        check("reset t_write_data", t_write_data, 0);
        check("reset t_write_enable", t_write_enable, 0);
        check("reset finish", compute_t_finish, 0);
        reset = 1'b0;

        run_block("zeros", -1, -1, 1);
        $display("zeros block done, %0d checks so far", n_checks);

        fill(0);
        sp_mem[0] = 16'sd256;
        run_block("dc256", -1, -1, 1);
        for (int j = 0; j < 8; j++) check($sformatf("dc256 T0[%0d] const", j), last_t[j], 1448);
        $display("dc256 block done");

        fill(0);
        sp_mem[1] = -16'sd1;
        run_block("neg1", -1, -1, 1);
        check("neg1 T0[0] const", last_t[0], -8);
        check("neg1 T0[7] const", last_t[7], 7);
        $display("neg1 block done");

        fill(1);
        for (int k = 0; k < 8; k++) sp_mem[k] = -16'sd32768;
        run_block("minrow", -1, -1, 1);
        check("minrow T0[0] const", last_t[0], -1384576);
        $display("minrow block done");

        fill(1);
        run_block("restart40", 40, -1, 1);
        $display("restart40 block done");

        fill(1);
        run_block("abort60", -1, 60, 0);
        $display("abort60 done");
        fill(1);
        run_block("after_abort", -1, -1, 1);
        $display("after_abort block done");

        fill(1);
        run_block("b2b_first", -1, -1, 0);
        fill(1);
        run_block("b2b_second", -1, -1, 2);
        $display("back-to-back blocks done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
